// File: rtl/ws2812_strip_driver.sv
// WS2812/SK6812 strip driver: streams NUM_LEDS pixels MSB-first from a valid/ready source,
// then holds the line low for the latch gap and pulses Done.
module ws2812_strip_driver #(
  parameter int unsigned F_CLK     = 12_000_000,
  parameter int unsigned NUM_LEDS  = 8,
  parameter int unsigned BITWIDTH  = 24,
  parameter int unsigned T0H_NS    = 350,
  parameter int unsigned T0L_NS    = 800,
  parameter int unsigned T1H_NS    = 700,
  parameter int unsigned T1L_NS    = 600,
  parameter int unsigned TRESET_US = 60
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [BITWIDTH-1:0] PixelData,
  input  logic                PixelValid,
  output logic                PixelReady,
  output logic                Ws2812Out,
  output logic                Busy,
  output logic                Done,
  output logic                Underrun
);

  function automatic int unsigned cycles_of(input int unsigned t, input int unsigned div);
    logic [63:0] c;
    c = 64'(t) * 64'(F_CLK) / 64'(div);
    return (c == 64'd0) ? 32'd1 : 32'(c);
  endfunction

  localparam int unsigned C0H  = cycles_of(T0H_NS, 1_000_000_000);
  localparam int unsigned C0L  = cycles_of(T0L_NS, 1_000_000_000);
  localparam int unsigned C1H  = cycles_of(T1H_NS, 1_000_000_000);
  localparam int unsigned C1L  = cycles_of(T1L_NS, 1_000_000_000);
  localparam int unsigned CRST = cycles_of(TRESET_US, 1_000_000);

  localparam int unsigned CBIT   = (C0H + C0L > C1H + C1L) ? C0H + C0L : C1H + C1L;
  localparam int unsigned CMAX   = (CRST > CBIT) ? CRST : CBIT;
  localparam int unsigned CW_RAW = $clog2(CMAX + 1);
  localparam int unsigned CW     = (CW_RAW < 16) ? 16 : CW_RAW;
  localparam int unsigned BW     = $clog2(BITWIDTH + 1);
  localparam int unsigned PW     = $clog2(NUM_LEDS + 1);

  // Counters load with length-1 and count down to zero.
  localparam logic [CW-1:0] K0H  = CW'(C0H - 1);
  localparam logic [CW-1:0] K0L  = CW'(C0L - 1);
  localparam logic [CW-1:0] K1H  = CW'(C1H - 1);
  localparam logic [CW-1:0] K1L  = CW'(C1L - 1);
  localparam logic [CW-1:0] KRST = CW'(CRST - 1);
  localparam logic [PW-1:0] NPIX = PW'(NUM_LEDS);

  typedef enum logic [2:0] {
    StIdle, StWaitFirst, StHigh, StLow, StLatch, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [BITWIDTH-1:0] shift_q, shift_d;
  logic [BITWIDTH-1:0] buf_q, buf_d;
  logic                buf_full_q, buf_full_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [PW-1:0]       sent_q, sent_d;
  logic                line_q, line_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                underrun_q, underrun_d;
  logic                load;
  logic                xfer;

  // Ready is also held low in StDone so a late pixel cannot be swallowed after an underrun.
  assign PixelReady = busy_q && !buf_full_q && (acc_q < NPIX) &&
                      (state_q != StLatch) && (state_q != StDone);
  assign xfer       = PixelValid && PixelReady;
  assign Ws2812Out  = line_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Underrun   = underrun_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    acc_d      = acc_q;
    sent_d     = sent_q;
    line_d     = line_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    underrun_d = underrun_q;
    load       = 1'b0;

    unique case (state_q)
      StIdle: begin
        line_d = 1'b0;
        if (Start) begin
          state_d    = StWaitFirst;
          busy_d     = 1'b1;
          underrun_d = 1'b0;
          acc_d      = '0;
          sent_d     = '0;
        end
      end
      StWaitFirst: begin
        if (buf_full_q) begin
          load    = 1'b1;
          state_d = StHigh;
          line_d  = 1'b1;
          cnt_d   = buf_q[BITWIDTH-1] ? K1H : K0H;
        end
      end
      StHigh: begin
        if (cnt_q == '0) begin
          state_d = StLow;
          line_d  = 1'b0;
          cnt_d   = shift_q[BITWIDTH-1] ? K1L : K0L;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StLow: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (bit_q != '0) begin
          shift_d = shift_q << 1;
          bit_d   = bit_q - BW'(1);
          state_d = StHigh;
          line_d  = 1'b1;
          cnt_d   = shift_q[BITWIDTH-2] ? K1H : K0H;
        end else if (sent_q == NPIX) begin
          state_d = StLatch;
          cnt_d   = KRST;
        end else if (buf_full_q) begin
          load    = 1'b1;
          state_d = StHigh;
          line_d  = 1'b1;
          cnt_d   = buf_q[BITWIDTH-1] ? K1H : K0H;
        end else begin
          underrun_d = 1'b1;
          state_d    = StLatch;
          cnt_d      = KRST;
        end
      end
      StLatch: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      shift_d = buf_q;
      bit_d   = BW'(BITWIDTH - 1);
      sent_d  = sent_q + PW'(1);
    end
    // Buffer drains on load and refills on transfer; both in one cycle leaves it full.
    buf_full_d = (buf_full_q && !load) || xfer;
    if (xfer) begin
      buf_d = PixelData;
      acc_d = acc_q + PW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      acc_q      <= '0;
      sent_q     <= '0;
      line_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      acc_q      <= acc_d;
      sent_q     <= sent_d;
      line_q     <= line_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

endmodule
